// File: rtl/button_mmio_if.sv
// Processor data-memory port as seen by the button MMIO block:
// a load/store strobe with a word address, and registered read data with a hit flag.
interface button_mmio_if;
    logic [11:0] addr;
    logic        rEn;
    logic        wEn;
    logic [31:0] dataOut;
    logic        hit;

    modport master (output addr, rEn, wEn, input  dataOut, hit);
    modport slave  (input  addr, rEn, wEn, output dataOut, hit);
endinterface

// File: rtl/button_mmio.sv
// Two debounced push-buttons exposed to the processor as memory-mapped registers:
// read-to-clear press flags and a pair of saturating 8-bit press counters.
module button_mmio #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] ADDR_BTN1       = 12'd7,
    parameter logic [11:0] ADDR_BTN2       = 12'd8,
    parameter logic [11:0] ADDR_CNT        = 12'd9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         btn_raw,
    button_mmio_if.slave       bus,
    output logic [1:0]         btn_level
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         sync1_q, sync2_q;
    logic [1:0][CW-1:0] dbc_q, dbc_d;
    logic [1:0]         level_q, level_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][7:0]    cnt_q, cnt_d;
    logic [31:0]        dout_q, dout_d;
    logic               hit_q, hit_d;

    logic               rd, wr_cnt;
    logic [1:0]         rd_clr, rise;

    always_comb begin
        level_d = level_q;
        dbc_d   = dbc_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_TC) begin
                dbc_d[i]   = '0;
                level_d[i] = sync2_q[i];
            end else begin
                dbc_d[i] = dbc_q[i] + CW'(1);
            end
        end
        rise = level_d & ~level_q;
    end

    // A simultaneous store wins over a load, so reads are qualified by !wEn.
    always_comb begin
        rd        = bus.rEn & ~bus.wEn;
        wr_cnt    = bus.wEn & (bus.addr == ADDR_CNT);
        rd_clr[0] = rd & (bus.addr == ADDR_BTN1);
        rd_clr[1] = rd & (bus.addr == ADDR_BTN2);

        hit_d  = 1'b0;
        dout_d = '0;
        if (rd_clr[0]) begin
            hit_d  = 1'b1;
            dout_d = {31'b0, press_q[0]};
        end else if (rd_clr[1]) begin
            hit_d  = 1'b1;
            dout_d = {31'b0, press_q[1]};
        end else if (rd & (bus.addr == ADDR_CNT)) begin
            hit_d  = 1'b1;
            dout_d = {16'b0, cnt_q[1], cnt_q[0]};
        end

        press_d = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            press_d[i] = rise[i] | (press_q[i] & ~rd_clr[i]);
            if (wr_cnt) begin
                cnt_d[i] = {7'b0, rise[i]};
            end else if (rise[i] && cnt_q[i] != 8'hFF) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dbc_q   <= '0;
            level_q <= '0;
            press_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            dbc_q   <= dbc_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.dataOut = dout_q;
    assign bus.hit     = hit_q;
    assign btn_level   = level_q;
endmodule
